// File: rtl/recur_controller.sv
// recur_controller: Moore sequencer for the memoised-recurrence datapath.
// Runs one stack-based evaluation per start, with host abort and a cycle-budget watchdog.
module recur_controller #(
  parameter int CNT_W       = 12,
  parameter int TIMEOUT_CYC = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             updated,
  input  logic             done,
  input  logic             backtrack,
  input  logic             cal_update,
  output logic             load_init,
  output logic             updater,
  output logic             push,
  output logic             alu,
  output logic             res_updater,
  output logic             cal_res,
  output logic             poping,
  output logic             dont_check,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic             error,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT     = 4'd1,
    S_EXPAND   = 4'd2,
    S_WAIT_UPD = 4'd3,
    S_PUSH     = 4'd4,
    S_EVAL     = 4'd5,
    S_DESCEND  = 4'd6,
    S_CALC     = 4'd7,
    S_WAIT_CAL = 4'd8,
    S_POP      = 4'd9,
    S_FINISH   = 4'd10
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  state_t           w_seq;
  state_t           w_next;
  logic             r_result_valid;
  logic             r_error;
  logic [CNT_W-1:0] r_cycles;
  logic             w_busy;
  logic             w_timeout;
  logic             w_abort;
  logic             w_launch;

  assign w_busy    = (r_state != S_IDLE);
  assign w_timeout = w_busy && (r_cycles == TIMEOUT_LAST);
  assign w_abort   = w_busy && abort;
  assign w_launch  = (r_state == S_IDLE) && start;

  // Sequencing transitions; each flag is only looked at in its own state.
  always_comb begin
    w_seq = r_state;
    case (r_state)
      S_IDLE:     if (start) w_seq = S_INIT; else w_seq = S_IDLE;
      S_INIT:     w_seq = S_EXPAND;
      S_EXPAND:   w_seq = S_WAIT_UPD;
      S_WAIT_UPD: if (updated) w_seq = S_PUSH; else w_seq = S_WAIT_UPD;
      S_PUSH:     w_seq = S_EVAL;
      S_EVAL: begin
        if (done)           w_seq = S_FINISH;
        else if (backtrack) w_seq = S_CALC;
        else                w_seq = S_DESCEND;
      end
      S_DESCEND:  w_seq = S_EXPAND;
      S_CALC:     w_seq = S_WAIT_CAL;
      S_WAIT_CAL: if (cal_update) w_seq = S_POP; else w_seq = S_WAIT_CAL;
      S_POP:      w_seq = S_EVAL;
      S_FINISH:   w_seq = S_IDLE;
      default:    w_seq = S_IDLE;
    endcase
  end

  // Watchdog and abort override any sequencing step (timeout reported as error).
  always_comb begin
    w_next = w_seq;
    if (w_timeout || w_abort) w_next = S_IDLE;
    else                      w_next = w_seq;
  end

  // State, sticky status flags and saturating run-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      r_cycles       <= '0;
    end else begin
      r_state <= w_next;

      if (w_launch)
        r_result_valid <= 1'b0;
      else if (r_state == S_FINISH && !w_timeout && !w_abort)
        r_result_valid <= 1'b1;
      else
        r_result_valid <= r_result_valid;

      if (w_launch)       r_error <= 1'b0;
      else if (w_timeout) r_error <= 1'b1;
      else                r_error <= r_error;

      if (w_launch)                    r_cycles <= '0;
      else if (w_busy && !(&r_cycles)) r_cycles <= r_cycles + CNT_W'(1);
      else                             r_cycles <= r_cycles;
    end
  end

  // One-hot strobe decode from the registered state only.
  always_comb begin
    load_init   = 1'b0;
    updater     = 1'b0;
    push        = 1'b0;
    alu         = 1'b0;
    res_updater = 1'b0;
    cal_res     = 1'b0;
    poping      = 1'b0;
    case (r_state)
      S_INIT:    load_init   = 1'b1;
      S_EXPAND:  updater     = 1'b1;
      S_PUSH:    push        = 1'b1;
      S_EVAL:    alu         = 1'b1;
      S_DESCEND: res_updater = 1'b1;
      S_CALC:    cal_res     = 1'b1;
      S_POP:     poping      = 1'b1;
      default:   load_init   = 1'b0;
    endcase
  end

  assign dont_check   = (r_state != S_EVAL);
  assign ready        = ~w_busy;
  assign busy         = w_busy;
  assign result_valid = r_result_valid;
  assign error        = r_error;
  assign cycles       = r_cycles;

endmodule
